bus_arbiter: RTL and testbench
==============================

// Module: bus_arbiter
// PURPOSE
//  Shares the single data-side system bus (DM, Timer0, Timer1, interrupt-generator register) between two
//  requesters: m0 = CPU M-stage load/store port, m1 = debug/test port. Decodes the address map, enforces
//  per-device wait states, sequences one transaction at a time and returns read data with a one-cycle
//  ready pulse. Illegal accesses complete with err=1 and no device strobe; the CPU raises AdEL/AdES from it.
// PARAMETERS
//  WAIT_DM   0  extra wait cycles for DM accesses (0..15)
//  WAIT_DEV  1  extra wait cycles for Timer0/Timer1/interrupt accesses (0..15)
// PORTS
//  clk        in   1   system clock, all state on rising edge
//  reset      in   1   asynchronous, active-high; clears all state
//  mN_req     in   1   N=0,1: request; held with addr/we/wdata/byteen until mN_ready
//  mN_we      in   1   1=store, 0=load
//  mN_addr    in   32  byte address
//  mN_wdata   in   32  store data, byte-lane aligned
//  mN_byteen  in   4   store byte enables (ignored for loads)
//  mN_rdata   out  32  load data, valid when mN_ready=1 and mN_err=0
//  mN_ready   out  1   one-cycle completion pulse
//  mN_err     out  1   with mN_ready: access illegal, no side effect
//  bus_addr   out  32  granted address; bus_wdata out 32; bus_byteen out 4
//  dm_we, tc0_we, tc1_we, int_we  out 1 each  one-cycle write strobes
//  dm_rdata, tc0_rdata, tc1_rdata, int_rdata  in 32 each  device read data
// BEHAVIOUR
//  Address map: DM 0x0000-0x2FFF; Timer0 0x7F00-0x7F0B; Timer1 0x7F10-0x7F1B; INT 0x7F20-0x7F23; else unmapped.
//  Illegal (err): unmapped; store to timer offset 0x8 (COUNT, read-only); store to Timer/INT with
//   byteen!=4'hF; any access to Timer/INT with addr[1:0]!=0.
//  FSM: IDLE -> ACCESS -> WAIT -> DONE -> IDLE.
//   IDLE: if any req, latch grant, addr, we, wdata, byteen, device select; legal -> ACCESS, illegal -> DONE(err).
//   ACCESS (1 cycle): bus_* driven from latches; exactly one *_we high iff we=1; load counter with WAIT_x.
//   WAIT: counter decrements; skipped when WAIT_x=0. On last ACCESS/WAIT cycle rdata captured into register.
//   DONE: granted mN_ready=1, mN_rdata=captured data (0 on err or store), mN_err as decoded; -> IDLE.
//  Latency: legal access with WAIT=k: ready in cycle k+2 after the IDLE edge that accepted req (DM,k=0: 2).
//   Illegal: ready in cycle 1. Next request accepted in IDLE the cycle after DONE (no back-to-back in DONE).
//  Requester changing req/addr before ready: ignored, latched values used; dropping req mid-transaction does
//   not abort, ready still pulses.
//  Non-granted requester sees ready=0, err=0; its req stays pending.
//  Simultaneous req: arbitration per CONFIGURATION; exactly one grant.
//  Outputs outside ACCESS: all *_we=0; bus_addr/wdata/byteen hold last latched value.
//  Reset (any time, incl. mid-ACCESS/WAIT): state=IDLE, all *_we=0, ready=0, err=0, rdata regs=0,
//   bus_addr/wdata=0, byteen=0, counter=0, priority pointer=m0. Aborted transaction never completes.
// CONFIGURATION
//  BUS_ARB_RR_EN defined: round-robin; pointer toggles to the other master after each grant; on tie the
//   master indicated by pointer wins.
//  BUS_ARB_RR_EN undefined: fixed priority, m0 always wins ties; pointer logic absent.
// TESTING
//  1 m0 load 0x0000_0100 (DM=0xDEADBEEF), WAIT_DM=0 -> m0_ready at cycle 2, rdata=0xDEADBEEF, err=0.
//  2 m1 store 0x7F04 wdata=0x10 byteen=F, WAIT_DEV=1 -> tc0_we one cycle in ACCESS, m1_ready cycle 3.
//  3 m0 store 0x7F08 or m0 load 0x3000 -> m0_ready cycle 1, err=1, no *_we asserted, rdata=0.
//  4 m0,m1 req together three times -> RR_EN: grants m0,m1,m0; without: m0 x3 while m0 req held.
//  5 reset asserted during WAIT of Timer1 load -> outputs zero immediately, no ready; reissued req completes.
//  6 m1 store 0x7F20 byteen=4'h1 -> err=1, int_we stays 0.

Source files
------------

// File: rtl/bus_arbiter.sv
// Two-master data-bus arbiter: decodes DM/Timer0/Timer1/INT, enforces per-device wait states, one transaction at a time.
// Define BUS_ARB_RR_EN for round-robin arbitration; otherwise m0 has fixed priority.
module bus_arbiter #(
  parameter int unsigned WAIT_DM  = 0,
  parameter int unsigned WAIT_DEV = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_byteen,
  output logic [31:0] m0_rdata,
  output logic        m0_ready,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_byteen,
  output logic [31:0] m1_rdata,
  output logic        m1_ready,
  output logic        m1_err,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_byteen,
  output logic        dm_we,
  output logic        tc0_we,
  output logic        tc1_we,
  output logic        int_we,
  input  logic [31:0] dm_rdata,
  input  logic [31:0] tc0_rdata,
  input  logic [31:0] tc1_rdata,
  input  logic [31:0] int_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_DONE} state_t;
  typedef enum logic [1:0] {DEV_DM, DEV_TC0, DEV_TC1, DEV_INT} dev_t;

  localparam logic [3:0] WDM  = 4'(WAIT_DM);
  localparam logic [3:0] WDEV = 4'(WAIT_DEV);

  state_t      state;
  dev_t        dev;
  logic        gnt;
  logic        lat_we;
  logic [3:0]  cnt;

  logic        any_req;
  logic        pick_m1;
  logic        s_we;
  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic [3:0]  s_byteen;
  dev_t        s_dev;
  logic        s_mapped;
  logic        s_illegal;
  logic [3:0]  wait_k;
  logic        last_cycle;
  logic [31:0] rd_dev;
  logic [31:0] rd_cap;

  assign any_req = m0_req | m1_req;

`ifdef BUS_ARB_RR_EN
  logic ptr;

  // On a tie the pointer picks the winner; it always moves to the master that lost.
  assign pick_m1 = m1_req & (~m0_req | ptr);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= 1'b0;
    end else if (state == S_IDLE && any_req) begin
      ptr <= ~pick_m1;
    end
  end
`else
  assign pick_m1 = m1_req & ~m0_req;
`endif

  always_comb begin
    s_we      = pick_m1 ? m1_we     : m0_we;
    s_addr    = pick_m1 ? m1_addr   : m0_addr;
    s_wdata   = pick_m1 ? m1_wdata  : m0_wdata;
    s_byteen  = pick_m1 ? m1_byteen : m0_byteen;
    s_dev     = DEV_DM;
    s_mapped  = 1'b1;
    if (s_addr <= 32'h0000_2FFF)
      s_dev = DEV_DM;
    else if (s_addr >= 32'h0000_7F00 && s_addr <= 32'h0000_7F0B)
      s_dev = DEV_TC0;
    else if (s_addr >= 32'h0000_7F10 && s_addr <= 32'h0000_7F1B)
      s_dev = DEV_TC1;
    else if (s_addr >= 32'h0000_7F20 && s_addr <= 32'h0000_7F23)
      s_dev = DEV_INT;
    else
      s_mapped = 1'b0;

    s_illegal = ~s_mapped;
    if (s_mapped && s_dev != DEV_DM) begin
      if (s_addr[1:0] != 2'b00)                          s_illegal = 1'b1;
      if (s_we && s_byteen != 4'hF)                      s_illegal = 1'b1;
      // Timer COUNT register at offset 0x8 is read-only.
      if (s_we && s_dev != DEV_INT && s_addr[3:0] == 4'h8) s_illegal = 1'b1;
    end
  end

  always_comb begin
    wait_k     = (dev == DEV_DM) ? WDM : WDEV;
    last_cycle = (state == S_ACCESS && wait_k == 4'd0) ||
                 (state == S_WAIT && cnt == 4'd1);
    rd_dev = dm_rdata;
    case (dev)
      DEV_DM:  rd_dev = dm_rdata;
      DEV_TC0: rd_dev = tc0_rdata;
      DEV_TC1: rd_dev = tc1_rdata;
      DEV_INT: rd_dev = int_rdata;
      default: rd_dev = dm_rdata;
    endcase
    rd_cap = lat_we ? '0 : rd_dev;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      dev        <= DEV_DM;
      gnt        <= 1'b0;
      lat_we     <= 1'b0;
      cnt        <= '0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      bus_byteen <= '0;
      dm_we      <= 1'b0;
      tc0_we     <= 1'b0;
      tc1_we     <= 1'b0;
      int_we     <= 1'b0;
      m0_ready   <= 1'b0;
      m0_err     <= 1'b0;
      m0_rdata   <= '0;
      m1_ready   <= 1'b0;
      m1_err     <= 1'b0;
      m1_rdata   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_req) begin
            gnt        <= pick_m1;
            lat_we     <= s_we;
            dev        <= s_dev;
            bus_addr   <= s_addr;
            bus_wdata  <= s_wdata;
            bus_byteen <= s_byteen;
            if (s_illegal) begin
              state    <= S_DONE;
              m0_ready <= ~pick_m1;
              m0_err   <= ~pick_m1;
              m1_ready <= pick_m1;
              m1_err   <= pick_m1;
              m0_rdata <= '0;
              m1_rdata <= '0;
            end else begin
              state  <= S_ACCESS;
              dm_we  <= s_we && s_dev == DEV_DM;
              tc0_we <= s_we && s_dev == DEV_TC0;
              tc1_we <= s_we && s_dev == DEV_TC1;
              int_we <= s_we && s_dev == DEV_INT;
            end
          end
        end
        S_ACCESS, S_WAIT: begin
          dm_we  <= 1'b0;
          tc0_we <= 1'b0;
          tc1_we <= 1'b0;
          int_we <= 1'b0;
          cnt    <= (state == S_ACCESS) ? wait_k : cnt - 4'd1;
          if (last_cycle) begin
            state    <= S_DONE;
            m0_ready <= ~gnt;
            m1_ready <= gnt;
            m0_rdata <= gnt ? '0 : rd_cap;
            m1_rdata <= gnt ? rd_cap : '0;
          end else begin
            state <= S_WAIT;
          end
        end
        S_DONE: begin
          state    <= S_IDLE;
          m0_ready <= 1'b0;
          m0_err   <= 1'b0;
          m0_rdata <= '0;
          m1_ready <= 1'b0;
          m1_err   <= 1'b0;
          m1_rdata <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter (WAIT_DM=0, WAIT_DEV=1); follows BUS_ARB_RR_EN for tie-break expectations.
module tb_bus_arbiter;

  logic        clk, reset;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_byteen, m1_byteen;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_ready, m0_err, m1_ready, m1_err;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_byteen;
  logic        dm_we, tc0_we, tc1_we, int_we;
  logic [31:0] dm_rdata, tc0_rdata, tc1_rdata, int_rdata;

  int checks = 0;
  int failures = 0;

  localparam logic [31:0] DM_D  = 32'hDEAD_BEEF;
  localparam logic [31:0] TC0_D = 32'h1111_0000;
  localparam logic [31:0] TC1_D = 32'h2222_0001;
  localparam logic [31:0] INT_D = 32'h3333_0002;

  bus_arbiter #(.WAIT_DM(0), .WAIT_DEV(1)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_byteen(m0_byteen),
    .m0_rdata(m0_rdata), .m0_ready(m0_ready), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_byteen(m1_byteen),
    .m1_rdata(m1_rdata), .m1_ready(m1_ready), .m1_err(m1_err),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_byteen(bus_byteen),
    .dm_we(dm_we), .tc0_we(tc0_we), .tc1_we(tc1_we), .int_we(int_we),
    .dm_rdata(dm_rdata), .tc0_rdata(tc0_rdata), .tc1_rdata(tc1_rdata), .int_rdata(int_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign dm_rdata  = DM_D;
  assign tc0_rdata = TC0_D;
  assign tc1_rdata = TC1_D;
  assign int_rdata = INT_D;

  // Drives one request and records when ready arrives (cycle 1 = cycle after the accepting edge).
  task automatic run_txn(input bit m, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, output int rc, output logic [31:0] rd, output logic er,
                         output logic [3:0] ws, output int wc, output logic other);
    rc = -1; rd = 'x; er = 1'bx; ws = '0; wc = 0; other = 1'b0;
    if (m) begin
      m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_byteen = be;
    end else begin
      m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_byteen = be;
    end
    for (int c = 1; c <= 20 && rc < 0; c++) begin
      @(posedge clk); #1;
      ws = ws | {dm_we, tc0_we, tc1_we, int_we};
      wc = wc + int'(dm_we) + int'(tc0_we) + int'(tc1_we) + int'(int_we);
      if (m ? (m0_ready | m0_err) : (m1_ready | m1_err)) other = 1'b1;
      if (m ? m1_ready : m0_ready) begin
        rc = c; rd = m ? m1_rdata : m0_rdata; er = m ? m1_err : m0_err;
      end
    end
    m0_req = 1'b0; m1_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #2 reset = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    checks++; if ({m0_ready, m0_err, m1_ready, m1_err, dm_we, tc0_we, tc1_we, int_we} !== 8'h00) begin
      failures++; $display("FAIL reset_ctrl got=%b exp=00000000", {m0_ready, m0_err, m1_ready, m1_err, dm_we, tc0_we, tc1_we, int_we}); end
    checks++; if ({m0_rdata, m1_rdata} !== 64'h0) begin
      failures++; $display("FAIL reset_rdata got=%h/%h exp=0", m0_rdata, m1_rdata); end
    checks++; if ({bus_addr, bus_wdata, bus_byteen} !== 68'h0) begin
      failures++; $display("FAIL reset_bus got=%h/%h/%h exp=0", bus_addr, bus_wdata, bus_byteen); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_dm();
    int rc, wc; logic [31:0] rd; logic er, ot; logic [3:0] ws;
    run_txn(1'b0, 1'b0, 32'h0000_0100, 32'h0, 4'h0, rc, rd, er, ws, wc, ot);
    checks++; if (rc !== 2) begin failures++; $display("FAIL dm_load_cycle got=%0d exp=2", rc); end
    checks++; if (rd !== DM_D) begin failures++; $display("FAIL dm_load_rdata got=%h exp=%h", rd, DM_D); end
    checks++; if (er !== 1'b0 || ws !== 4'h0) begin failures++; $display("FAIL dm_load_err_we got=%b/%b exp=0/0000", er, ws); end
    checks++; if (bus_addr !== 32'h0000_0100) begin failures++; $display("FAIL dm_load_bus_addr got=%h exp=00000100", bus_addr); end
    run_txn(1'b0, 1'b1, 32'h0000_2FFF, 32'hA500_0000, 4'h8, rc, rd, er, ws, wc, ot);
    checks++; if (rc !== 2) begin failures++; $display("FAIL dm_store_cycle got=%0d exp=2", rc); end
    checks++; if (ws !== 4'b1000 || wc !== 1) begin failures++; $display("FAIL dm_store_we got=%b/%0d exp=1000/1", ws, wc); end
    checks++; if (rd !== 32'h0 || er !== 1'b0) begin failures++; $display("FAIL dm_store_rd_err got=%h/%b exp=0/0", rd, er); end
    checks++; if ({bus_addr, bus_wdata, bus_byteen} !== {32'h0000_2FFF, 32'hA500_0000, 4'h8}) begin
      failures++; $display("FAIL dm_store_bus got=%h/%h/%h exp=00002fff/a5000000/8", bus_addr, bus_wdata, bus_byteen); end
  endtask

  task automatic test_devices();
    int rc, wc; logic [31:0] rd; logic er, ot; logic [3:0] ws;
    run_txn(1'b1, 1'b1, 32'h0000_7F04, 32'h10, 4'hF, rc, rd, er, ws, wc, ot);
    checks++; if (rc !== 3) begin failures++; $display("FAIL tc0_store_cycle got=%0d exp=3", rc); end
    checks++; if (ws !== 4'b0100 || wc !== 1) begin failures++; $display("FAIL tc0_store_we got=%b/%0d exp=0100/1", ws, wc); end
    checks++; if (er !== 1'b0 || ot !== 1'b0) begin failures++; $display("FAIL tc0_store_err_other got=%b/%b exp=0/0", er, ot); end
    checks++; if (bus_wdata !== 32'h10) begin failures++; $display("FAIL tc0_store_wdata got=%h exp=00000010", bus_wdata); end
    run_txn(1'b1, 1'b0, 32'h0000_7F14, 32'h0, 4'h0, rc, rd, er, ws, wc, ot);
    checks++; if (rc !== 3 || rd !== TC1_D) begin failures++; $display("FAIL tc1_load got=%0d/%h exp=3/%h", rc, rd, TC1_D); end
    run_txn(1'b0, 1'b0, 32'h0000_7F20, 32'h0, 4'h0, rc, rd, er, ws, wc, ot);
    checks++; if (rc !== 3 || rd !== INT_D) begin failures++; $display("FAIL int_load got=%0d/%h exp=3/%h", rc, rd, INT_D); end
    run_txn(1'b0, 1'b0, 32'h0000_7F08, 32'h0, 4'h0, rc, rd, er, ws, wc, ot);
    checks++; if (rc !== 3 || rd !== TC0_D || er !== 1'b0) begin
      failures++; $display("FAIL tc0_count_load got=%0d/%h/%b exp=3/%h/0", rc, rd, er, TC0_D); end
  endtask

  task automatic test_illegal();
    int rc, wc; logic [31:0] rd; logic er, ot; logic [3:0] ws;
    logic [31:0] addrs [5] = '{32'h0000_7F08, 32'h0000_3000, 32'h0000_7F02, 32'h0000_7F0C, 32'h0000_7F18};
    bit          wes   [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      run_txn(1'b0, wes[i], addrs[i], 32'h5555_AAAA, 4'hF, rc, rd, er, ws, wc, ot);
      checks++; if (rc !== 1 || er !== 1'b1 || rd !== 32'h0 || ws !== 4'h0) begin
        failures++; $display("FAIL illegal_%0d got=cyc%0d/err%b/%h/we%b exp=cyc1/err1/0/we0000", i, rc, er, rd, ws); end
    end
    run_txn(1'b1, 1'b1, 32'h0000_7F20, 32'h0000_0001, 4'h1, rc, rd, er, ws, wc, ot);
    checks++; if (rc !== 1 || er !== 1'b1 || ws !== 4'h0) begin
      failures++; $display("FAIL int_byteen got=cyc%0d/err%b/we%b exp=cyc1/err1/we0000", rc, er, ws); end
  endtask

  task automatic test_hold_latch();
    int rc = -1; logic [31:0] rd = '0; logic [3:0] ws = '0;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0000_7F04; m0_byteen = 4'h0;
    @(posedge clk); #1;
    m0_req = 1'b0; m0_we = 1'b1; m0_addr = 32'h0000_0100; m0_byteen = 4'hF;
    for (int c = 2; c <= 10 && rc < 0; c++) begin
      @(posedge clk); #1;
      ws = ws | {dm_we, tc0_we, tc1_we, int_we};
      if (m0_ready) begin rc = c; rd = m0_rdata; end
    end
    checks++; if (rc !== 3 || rd !== TC0_D) begin failures++; $display("FAIL hold_latch got=%0d/%h exp=3/%h", rc, rd, TC0_D); end
    checks++; if (bus_addr !== 32'h0000_7F04 || ws !== 4'h0) begin
      failures++; $display("FAIL hold_latch_bus got=%h/%b exp=00007f04/0000", bus_addr, ws); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int gcnt = 0; logic [2:0] seq = '0; int cyc [3] = '{-1, -1, -1}; logic both = 1'b0;
    logic [2:0] exp_seq;
`ifdef BUS_ARB_RR_EN
    exp_seq = 3'b010;
`else
    exp_seq = 3'b000;
`endif
    reset = 1'b1; @(posedge clk); #1; reset = 1'b0;
    m0_we = 1'b0; m0_addr = 32'h0000_0100; m1_we = 1'b0; m1_addr = 32'h0000_0200;
    m0_req = 1'b1; m1_req = 1'b1;
    for (int c = 1; c <= 40 && gcnt < 3; c++) begin
      @(posedge clk); #1;
      if (m0_ready && m1_ready) both = 1'b1;
      if (m0_ready || m1_ready) begin seq[gcnt] = m1_ready; cyc[gcnt] = c; gcnt++; end
    end
    m0_req = 1'b0; m1_req = 1'b0;
    @(posedge clk); #1;
    checks++; if (gcnt !== 3 || both !== 1'b0) begin failures++; $display("FAIL arb_count got=%0d/%b exp=3/0", gcnt, both); end
    checks++; if (seq !== exp_seq) begin failures++; $display("FAIL arb_order got=%b exp=%b", seq, exp_seq); end
    checks++; if (cyc[0] !== 2 || cyc[1] !== 5 || cyc[2] !== 8) begin
      failures++; $display("FAIL arb_spacing got=%0d,%0d,%0d exp=2,5,8", cyc[0], cyc[1], cyc[2]); end
  endtask

  task automatic test_reset_mid();
    int rc, wc; logic [31:0] rd; logic er, ot; logic [3:0] ws; logic seen = 1'b0;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h0000_7F14; m1_byteen = 4'h0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (bus_addr !== 32'h0000_7F14 || m1_ready !== 1'b0) begin
      failures++; $display("FAIL rst_mid_pre got=%h/%b exp=00007f14/0", bus_addr, m1_ready); end
    reset = 1'b1; m1_req = 1'b0;
    #1;
    checks++; if ({bus_addr, m1_ready, m1_err, m1_rdata, tc1_we} !== 67'h0) begin
      failures++; $display("FAIL rst_mid_outputs got=%h/%b/%b/%h/%b exp=0", bus_addr, m1_ready, m1_err, m1_rdata, tc1_we); end
    for (int c = 0; c < 2; c++) begin @(posedge clk); #1; seen = seen | m1_ready | m0_ready; end
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin @(posedge clk); #1; seen = seen | m1_ready | m0_ready; end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL rst_mid_no_ready got=%b exp=0", seen); end
    run_txn(1'b1, 1'b0, 32'h0000_7F14, 32'h0, 4'h0, rc, rd, er, ws, wc, ot);
    checks++; if (rc !== 3 || rd !== TC1_D || er !== 1'b0) begin
      failures++; $display("FAIL rst_mid_reissue got=%0d/%h/%b exp=3/%h/0", rc, rd, er, TC1_D); end
  endtask

  initial begin
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0; m0_byteen = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0; m1_byteen = '0;
    test_reset();
    test_dm();
    test_devices();
    test_illegal();
    test_hold_latch();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
